div_share_ctrl: RTL and testbench

Sequencer and two-port arbiter for the shared 32-bit signed iterative divider core (`Divider_32`). It accepts divide requests from two requesters, such as the integer pipe DIV path and the address/trap unit. It grants them round-robin and drives the core's operands and `start` pulse train. It waits the core's fixed latency, then returns the quotient to the owning requester. Divide-by-zero and the signed-overflow case never reach the core; they are resolved in one cycle.

---
 rtl/div_share_ctrl_if.sv | 54 +++++
 rtl/div_share_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_share_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_share_ctrl_if
// Bundle of every non-clock signal of the shared-divider controller.
//   req0_* / req1_*   : request handshake and signed operands per requester
//   resp0_* / resp1_* : one-cycle result pulse, quotient and div-by-zero flag
//   busy              : controller is not idle
//   core_*            : operand / start / quotient lines of the divider core
// Modports:
//   slave  - controller view (div_share_ctrl)
//   master - environment view (requesters plus the divider core)
// ---------------------------------------------------------------------------
interface div_share_ctrl_if #(
    parameter int BITS = 32
);
    logic            req0_valid;
    logic [BITS-1:0] req0_dividend;
    logic [BITS-1:0] req0_divisor;
    logic            req0_ready;
    logic            resp0_valid;
    logic [BITS-1:0] resp0_quotient;
    logic            resp0_dbz;

    logic            req1_valid;
    logic [BITS-1:0] req1_dividend;
    logic [BITS-1:0] req1_divisor;
    logic            req1_ready;
    logic            resp1_valid;
    logic [BITS-1:0] resp1_quotient;
    logic            resp1_dbz;

    logic            busy;
    logic [BITS-1:0] core_dividend;
    logic [BITS-1:0] core_divisor;
    logic            core_start;
    logic [BITS-1:0] core_quotient;

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  core_quotient,
        output req0_ready, resp0_valid, resp0_quotient, resp0_dbz,
        output req1_ready, resp1_valid, resp1_quotient, resp1_dbz,
        output busy, core_dividend, core_divisor, core_start
    );

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output core_quotient,
        input  req0_ready, resp0_valid, resp0_quotient, resp0_dbz,
        input  req1_ready, resp1_valid, resp1_quotient, resp1_dbz,
        input  busy, core_dividend, core_divisor, core_start
    );
endinterface

// File: rtl/div_share_ctrl.sv
// ---------------------------------------------------------------------------
// div_share_ctrl
// Round-robin sequencer that shares one iterative signed divider core between
// two requesters. Divide-by-zero and MIN/-1 overflow are answered directly
// without launching the core.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : div_share_ctrl_if.slave (requests, responses, core lines, busy)
// Parameters:
//   BITS       : operand / quotient width
//   START_HOLD : cycles core_start stays high per launch
//   LATENCY    : cycles from first core_start cycle to quotient capture cycle
// ---------------------------------------------------------------------------
module div_share_ctrl #(
    parameter int BITS       = 32,
    parameter int START_HOLD = 4,
    parameter int LATENCY    = 36
) (
    input  logic             clock,
    input  logic             reset,
    div_share_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    localparam int              CW      = $clog2(LATENCY + 1);
    localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] dividend_q, dividend_d;
    logic [BITS-1:0] divisor_q, divisor_d;
    logic [BITS-1:0] result_q, result_d;
    logic            dbz_q, dbz_d;

    logic [1:0]      req_valid;
    logic [1:0]      grant;
    logic            acc_id;
    logic [BITS-1:0] acc_dividend;
    logic [BITS-1:0] acc_divisor;
    logic            is_dbz;
    logic            is_ovf;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // A requester wins when it is the only one asking, or when both ask and
    // the round-robin pointer names it. Grants only exist in IDLE.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = (state_q == S_IDLE) && req_valid[gi] &&
                               (!req_valid[1-gi] || (rr_q == 1'(gi)));
        end
    endgenerate

    assign acc_id       = grant[1];
    assign acc_dividend = acc_id ? bus.req1_dividend : bus.req0_dividend;
    assign acc_divisor  = acc_id ? bus.req1_divisor  : bus.req0_divisor;
    assign is_dbz       = (acc_divisor == '0);
    assign is_ovf       = (acc_dividend == MIN_NEG) && (acc_divisor == '1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            dbz_q      <= dbz_d;
        end
    end

    // Next-state logic. cnt equals k during the k-th cycle after accept.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        dbz_d      = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    owner_d    = acc_id;
                    rr_d       = ~acc_id;
                    dividend_d = acc_dividend;
                    divisor_d  = acc_divisor;
                    if (is_dbz) begin
                        result_d = '1;
                        dbz_d    = 1'b1;
                        state_d  = S_RESP;
                    end else if (is_ovf) begin
                        result_d = acc_dividend;
                        dbz_d    = 1'b0;
                        state_d  = S_RESP;
                    end else begin
                        dbz_d    = 1'b0;
                        cnt_d    = CW'(1);
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                // LATENCY may equal START_HOLD, so capture can happen here.
                if (cnt_q == CW'(LATENCY)) begin
                    result_d = bus.core_quotient;
                    cnt_d    = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(START_HOLD)) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(LATENCY)) begin
                    result_d = bus.core_quotient;
                    cnt_d    = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.req0_ready     = grant[0];
        bus.req1_ready     = grant[1];
        bus.busy           = (state_q != S_IDLE);
        bus.core_start     = (state_q == S_LAUNCH);
        bus.core_dividend  = dividend_q;
        bus.core_divisor   = divisor_q;
        bus.resp0_valid    = (state_q == S_RESP) && (owner_q == 1'b0);
        bus.resp1_valid    = (state_q == S_RESP) && (owner_q == 1'b1);
        bus.resp0_quotient = result_q;
        bus.resp1_quotient = result_q;
        bus.resp0_dbz      = dbz_q;
        bus.resp1_dbz      = dbz_q;
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_share_ctrl
// Directed bench for div_share_ctrl. A small behavioural divider core answers
// core launches: it presents the true quotient only in the LATENCY-th cycle
// after launch and a junk value otherwise.
// ---------------------------------------------------------------------------
module tb_div_share_ctrl;
    localparam int BITS       = 32;
    localparam int START_HOLD = 4;
    localparam int LATENCY    = 36;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_share_ctrl_if #(.BITS(BITS)) dbus ();

    div_share_ctrl #(
        .BITS      (BITS),
        .START_HOLD(START_HOLD),
        .LATENCY   (LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (dbus)
    );

    always #5 clock = ~clock;

    // Behavioural core: core_cyc == k during the k-th cycle after accept.
    int          core_cyc = 0;
    logic [31:0] core_res;

    always @(posedge clock) begin
        if (reset) begin
            core_cyc <= 0;
        end else if (core_cyc == 0) begin
            if (dbus.core_start) begin
                core_cyc <= 2;
                core_res <= $signed(dbus.core_dividend) / $signed(dbus.core_divisor);
            end
        end else begin
            core_cyc <= (core_cyc == LATENCY) ? 0 : core_cyc + 1;
        end
    end

    assign dbus.core_quotient = (core_cyc == LATENCY) ? core_res : 32'hDEADBEEF;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"},       32'(dbus.busy), 0);
        chk({tag, " core_start"}, 32'(dbus.core_start), 0);
        chk({tag, " resp0_valid"},32'(dbus.resp0_valid), 0);
        chk({tag, " resp1_valid"},32'(dbus.resp1_valid), 0);
        chk({tag, " core_dvd"},   dbus.core_dividend, 0);
        chk({tag, " core_dvs"},   dbus.core_divisor, 0);
        chk({tag, " resp0_q"},    dbus.resp0_quotient, 0);
        chk({tag, " resp1_q"},    dbus.resp1_quotient, 0);
        chk({tag, " resp0_dbz"},  32'(dbus.resp0_dbz), 0);
        chk({tag, " resp1_dbz"},  32'(dbus.resp1_dbz), 0);
    endtask

    // Walk cycles A+1 .. A+n (RESP is A+n); caller has already ticked into A+1.
    task automatic follow(input string tag, input int n, input int hold, input bit owner,
                          input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] q, input bit dbz);
        logic        own_v, oth_v, own_dbz;
        logic [31:0] own_q;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) tick();
            own_v   = owner ? dbus.resp1_valid    : dbus.resp0_valid;
            oth_v   = owner ? dbus.resp0_valid    : dbus.resp1_valid;
            own_q   = owner ? dbus.resp1_quotient : dbus.resp0_quotient;
            own_dbz = owner ? dbus.resp1_dbz      : dbus.resp0_dbz;
            chk({tag, " busy"},       32'(dbus.busy), 1);
            chk({tag, " core_start"}, 32'(dbus.core_start), 32'(k <= hold));
            chk({tag, " resp_valid"}, 32'(own_v), 32'(k == n));
            chk({tag, " other_valid"},32'(oth_v), 0);
            chk({tag, " ready0"},     32'(dbus.req0_ready), 0);
            chk({tag, " ready1"},     32'(dbus.req1_ready), 0);
            if (k == 1 || k == n) begin
                chk({tag, " core_dvd"}, dbus.core_dividend, dvd);
                chk({tag, " core_dvs"}, dbus.core_divisor, dvs);
            end
            if (k == n) begin
                chk({tag, " quotient"}, own_q, q);
                chk({tag, " dbz"},      32'(own_dbz), 32'(dbz));
                $display("txn %s: owner=%0d dividend=%h divisor=%h quotient=%h dbz=%0b",
                         tag, owner, dvd, dvs, own_q, own_dbz);
            end
        end
    endtask

    initial begin
        dbus.req0_valid = 1'b0; dbus.req0_dividend = '0; dbus.req0_divisor = '0;
        dbus.req1_valid = 1'b0; dbus.req1_dividend = '0; dbus.req1_divisor = '0;

        // Reset state
        tick(); tick();
        chk_reset("reset");
        chk("reset ready0", 32'(dbus.req0_ready), 0);
        reset = 1'b0;
        tick();

        // Contention after reset: req0 100/7 wins first
        dbus.req0_dividend = 32'd100;        dbus.req0_divisor = 32'd7;
        dbus.req1_dividend = 32'hFFFFFFF7;   dbus.req1_divisor = 32'd2;
        dbus.req0_valid = 1'b1; dbus.req1_valid = 1'b1;
        #1;
        chk("cont ready0", 32'(dbus.req0_ready), 1);
        chk("cont ready1", 32'(dbus.req1_ready), 0);
        tick();
        dbus.req0_valid = 1'b0; dbus.req0_dividend = 32'd5;  // post-accept change
        follow("cont0", LATENCY + 1, START_HOLD, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
        tick();
        chk("cont1 ready1", 32'(dbus.req1_ready), 1);
        chk("cont1 ready0", 32'(dbus.req0_ready), 0);
        chk("cont1 busy",   32'(dbus.busy), 0);
        tick();
        dbus.req1_valid = 1'b0;
        follow("cont1", LATENCY + 1, START_HOLD, 1'b1, 32'hFFFFFFF7, 32'd2, 32'hFFFFFFFC, 1'b0);

        // Third simultaneous pair goes to req0, then strictly alternates
        tick();
        dbus.req0_dividend = 32'd9; dbus.req0_divisor = 32'd3;
        dbus.req1_dividend = 32'd8; dbus.req1_divisor = 32'd2;
        dbus.req0_valid = 1'b1; dbus.req1_valid = 1'b1;
        #1;
        chk("pair3 ready0", 32'(dbus.req0_ready), 1);
        chk("pair3 ready1", 32'(dbus.req1_ready), 0);
        tick();
        dbus.req0_valid = 1'b0;
        follow("pair3a", LATENCY + 1, START_HOLD, 1'b0, 32'd9, 32'd3, 32'd3, 1'b0);
        tick();
        chk("pair3b ready1", 32'(dbus.req1_ready), 1);
        tick();
        dbus.req1_valid = 1'b0;
        follow("pair3b", LATENCY + 1, START_HOLD, 1'b1, 32'd8, 32'd2, 32'd4, 1'b0);

        // Signed divide, req0 only: -440 / -5 = 88
        tick();
        dbus.req0_dividend = 32'hFFFFFE48; dbus.req0_divisor = 32'hFFFFFFFB;
        dbus.req0_valid = 1'b1;
        #1;
        chk("neg ready0", 32'(dbus.req0_ready), 1);
        chk("neg ready1", 32'(dbus.req1_ready), 0);
        tick();
        dbus.req0_valid = 1'b0; dbus.req0_divisor = 32'd1;
        follow("neg", LATENCY + 1, START_HOLD, 1'b0, 32'hFFFFFE48, 32'hFFFFFFFB, 32'd88, 1'b0);

        // Divide by zero on req1: bypass, answer in A+1
        tick();
        dbus.req1_dividend = 32'd1234; dbus.req1_divisor = 32'd0;
        dbus.req1_valid = 1'b1;
        #1;
        chk("dbz ready1", 32'(dbus.req1_ready), 1);
        tick();
        dbus.req1_valid = 1'b0;
        follow("dbz", 1, 0, 1'b1, 32'd1234, 32'd0, 32'hFFFFFFFF, 1'b1);
        tick();
        chk("dbz idle busy",  32'(dbus.busy), 0);
        chk("dbz idle start", 32'(dbus.core_start), 0);

        // Overflow on req0: MIN / -1 wraps to MIN, no core launch
        dbus.req0_dividend = 32'h80000000; dbus.req0_divisor = 32'hFFFFFFFF;
        dbus.req0_valid = 1'b1;
        #1;
        chk("ovf ready0", 32'(dbus.req0_ready), 1);
        tick();
        dbus.req0_valid = 1'b0;
        follow("ovf", 1, 0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        tick();
        chk("ovf idle busy", 32'(dbus.busy), 0);

        // Reset mid-operation at A+10 of 50/5
        dbus.req0_dividend = 32'd50; dbus.req0_divisor = 32'd5;
        dbus.req0_valid = 1'b1;
        #1;
        chk("abort ready0", 32'(dbus.req0_ready), 1);
        tick();
        dbus.req0_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) tick();
            chk("abort core_start", 32'(dbus.core_start), 32'(k <= START_HOLD));
        end
        reset = 1'b1;
        tick();
        chk_reset("abort");
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("abort no resp0", 32'(dbus.resp0_valid), 0);
            chk("abort idle busy", 32'(dbus.busy), 0);
        end

        // Fresh 50/5 with req1 held throughout; rr must be back at req0
        dbus.req0_dividend = 32'd50;  dbus.req0_divisor = 32'd5;
        dbus.req1_dividend = 32'd999; dbus.req1_divisor = 32'd9;
        dbus.req0_valid = 1'b1; dbus.req1_valid = 1'b1;
        #1;
        chk("fresh ready0", 32'(dbus.req0_ready), 1);
        chk("fresh ready1", 32'(dbus.req1_ready), 0);
        tick();
        dbus.req0_valid = 1'b0;
        follow("fresh", LATENCY + 1, START_HOLD, 1'b0, 32'd50, 32'd5, 32'd10, 1'b0);
        tick();
        dbus.req1_dividend = 32'd21; dbus.req1_divisor = 32'd7;
        #1;
        chk("held ready1", 32'(dbus.req1_ready), 1);
        tick();
        dbus.req1_valid = 1'b0;
        follow("held", LATENCY + 1, START_HOLD, 1'b1, 32'd21, 32'd7, 32'd3, 1'b0);
        tick();
        chk("final busy", 32'(dbus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
